// File: rtl/quantr_mem_arbiter.sv
// Two-requester (IF / LS) arbiter for the single quantr_i memory port; one read in flight at a time.
// Optional macro QUANTR_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed LS-over-IF priority.
module quantr_mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("quantr_mem_arbiter: MEM_LATENCY must be within 1..15");
  end

  localparam logic [3:0] LAT    = 4'(MEM_LATENCY);
  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_LS = 1'b1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nx;
  logic              owner, owner_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              ce_nx, if_gnt_nx, ls_gnt_nx, if_rvalid_nx, ls_rvalid_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] if_rdata_nx, ls_rdata_nx;
  logic              ls_wins;

`ifdef QUANTR_ARB_ROUND_ROBIN_EN
  // On a tie the port that did not own the previous transaction wins.
  assign ls_wins = ls_req && (!if_req || (owner == OWN_IF));
`else
  assign ls_wins = ls_req;
`endif

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    cnt_nx       = cnt;
    ce_nx        = mem_ce_o;
    addr_nx      = mem_addr_o;
    if_gnt_nx    = 1'b0;
    ls_gnt_nx    = 1'b0;
    if_rvalid_nx = 1'b0;
    ls_rvalid_nx = 1'b0;
    if_rdata_nx  = if_rdata;
    ls_rdata_nx  = ls_rdata;
    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          owner_nx  = ls_wins ? OWN_LS : OWN_IF;
          addr_nx   = ls_wins ? ls_addr : if_addr;
          ls_gnt_nx = ls_wins;
          if_gnt_nx = !ls_wins;
          ce_nx     = 1'b1;
          cnt_nx    = LAT;
          state_nx  = ACCESS;
        end
      end
      ACCESS: begin
        cnt_nx = cnt - 4'd1;
        // Memory data is valid on the edge that ends the last latency cycle.
        if (cnt == 4'd1) begin
          if (owner == OWN_LS) begin
            ls_rdata_nx  = mem_rdata_i;
            ls_rvalid_nx = 1'b1;
          end else begin
            if_rdata_nx  = mem_rdata_i;
            if_rvalid_nx = 1'b1;
          end
          ce_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      mem_ce_o   <= 1'b0;
      mem_addr_o <= '0;
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      cnt        <= cnt_nx;
      mem_ce_o   <= ce_nx;
      mem_addr_o <= addr_nx;
      if_gnt     <= if_gnt_nx;
      ls_gnt     <= ls_gnt_nx;
      if_rvalid  <= if_rvalid_nx;
      ls_rvalid  <= ls_rvalid_nx;
      if_rdata   <= if_rdata_nx;
      ls_rdata   <= ls_rdata_nx;
    end
  end

endmodule

// File: tb/tb_quantr_mem_arbiter.sv
// Bench for quantr_mem_arbiter: two instances (MEM_LATENCY 1 and 3), each with a timeline model and
// directed plus random requests; honours QUANTR_ARB_ROUND_ROBIN_EN in the arbitration rule.
module tb_quantr_mem_arbiter;

  logic clk;
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL u%0d.%s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    if (a == 64'h1000) return 32'h0000_0013;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_n, if_req, ls_req;
    logic [63:0] if_addr, ls_addr, mem_addr;
    logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_ce;
    logic [31:0] if_rdata, ls_rdata, mem_rdata;
    bit          done = 1'b0;

    assign mem_rdata = mem_f(mem_addr);

    quantr_mem_arbiter #(.ADDR_W(64), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_ce_o(mem_ce), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
    );

    // Timeline model: edge count since reset, grant edge, data edge, first edge the port is free again.
    int          m_e = 0, m_g = -100, m_d = -100, m_free = 0;
    bit          m_own_ls = 1'b0, m_last_ls = 1'b0, pick;
    logic [63:0] m_addr = '0;
    logic [31:0] m_if_rd = '0, m_ls_rd = '0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_e = 0; m_g = -100; m_d = -100; m_free = 0;
        m_own_ls = 1'b0; m_last_ls = 1'b0;
        m_addr = '0; m_if_rd = '0; m_ls_rd = '0;
      end else begin
        m_e++;
        if (m_e == m_d) begin
          if (m_own_ls) m_ls_rd = mem_f(m_addr);
          else          m_if_rd = mem_f(m_addr);
        end
        if (m_e >= m_free && (if_req || ls_req)) begin
`ifdef QUANTR_ARB_ROUND_ROBIN_EN
          pick = ls_req && (!if_req || !m_last_ls);
`else
          pick = ls_req;
`endif
          m_own_ls = pick; m_last_ls = pick;
          m_addr = pick ? ls_addr : if_addr;
          m_g = m_e; m_d = m_e + LAT; m_free = m_e + LAT + 1;
        end
      end
    end

    always @(negedge clk) begin
      chk(g, "if_gnt",    64'(if_gnt),    64'(m_e == m_g && !m_own_ls));
      chk(g, "ls_gnt",    64'(ls_gnt),    64'(m_e == m_g &&  m_own_ls));
      chk(g, "if_rvalid", 64'(if_rvalid), 64'(m_e == m_d && !m_own_ls));
      chk(g, "ls_rvalid", 64'(ls_rvalid), 64'(m_e == m_d &&  m_own_ls));
      chk(g, "mem_ce",    64'(mem_ce),    64'(m_e >= m_g && m_e < m_d));
      chk(g, "mem_addr",  mem_addr,       m_addr);
      chk(g, "if_rdata",  64'(if_rdata),  64'(m_if_rd));
      chk(g, "ls_rdata",  64'(ls_rdata),  64'(m_ls_rd));
    end

    task automatic random_phase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 199) == 0) begin
          @(posedge clk);
          #2 rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end
        if ($urandom_range(0, 1) == 1) begin
          if_req  = ($urandom_range(0, 9) < 6);
          if_addr = {32'($urandom_range(0, 3)), $urandom};
        end
        if ($urandom_range(0, 1) == 1) begin
          ls_req  = ($urandom_range(0, 9) < 5);
          ls_addr = {$urandom, $urandom};
        end
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      repeat (LAT + 2) @(negedge clk);
    endtask

    if (g == 0) begin : g_lat1
      initial begin
        int got, last, k;
        bit exp_ord [4];
`ifdef QUANTR_ARB_ROUND_ROBIN_EN
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst_n = 1'b1; if_req = 1'b1; if_addr = 64'h1000; ls_req = 1'b0; ls_addr = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk(g, "rst if_rdata", 64'(if_rdata), 64'h0);
        rst_n = 1'b1;
        // Single IF read straight out of reset.
        @(negedge clk);
        chk(g, "t1 if_gnt", 64'(if_gnt), 64'd1);
        chk(g, "t1 addr", mem_addr, 64'h1000);
        if_req = 1'b0;
        @(negedge clk);
        chk(g, "t1 if_rvalid", 64'(if_rvalid), 64'd1);
        chk(g, "t1 if_rdata", 64'(if_rdata), 64'h13);
        chk(g, "t1 ls_rdata", 64'(ls_rdata), 64'h0);
        // Simultaneous requests: LS first, then IF.
        if_req = 1'b1; if_addr = 64'h1000; ls_req = 1'b1; ls_addr = 64'h2000;
        @(negedge clk);
        chk(g, "t2 ls_gnt", 64'(ls_gnt), 64'd1);
        chk(g, "t2 if_gnt", 64'(if_gnt), 64'd0);
        ls_req = 1'b0;
        @(negedge clk);
        chk(g, "t2 ls_rvalid", 64'(ls_rvalid), 64'd1);
        chk(g, "t2 ls_rdata", 64'(ls_rdata), 64'(mem_f(64'h2000)));
        @(negedge clk);
        chk(g, "t2 if_gnt2", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        @(negedge clk);
        chk(g, "t2 if_rvalid", 64'(if_rvalid), 64'd1);
        chk(g, "t2 ls_rvalid0", 64'(ls_rvalid), 64'd0);
        // Both held: grant order depends on arbitration mode.
        if_req = 1'b1; if_addr = 64'h1100; ls_req = 1'b1; ls_addr = 64'h2200;
        for (int n = 0; n < 4; n++) begin
          got = -1;
          for (int t = 0; t < 6 && got < 0; t++) begin
            @(negedge clk);
            if (ls_gnt) got = 1;
            else if (if_gnt) got = 0;
          end
          chk(g, "t3 order", 64'(got), 64'(exp_ord[n]));
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(negedge clk);
        // Streaming IF fetch with incrementing addresses.
        if_addr = 64'h3000; if_req = 1'b1; last = -1; k = 0;
        for (int t = 0; t < 12; t++) begin
          @(negedge clk);
          if (if_rvalid) begin
            chk(g, "t6 rdata", 64'(if_rdata), 64'(mem_f(64'h3000 + 64'(4 * k))));
            if (last >= 0) chk(g, "t6 spacing", 64'(t - last), 64'd2);
            last = t;
            k++;
          end
          if (if_gnt) if_addr = if_addr + 64'd4;
        end
        chk(g, "t6 count", 64'(k), 64'd6);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        random_phase(800);
        done = 1'b1;
      end
    end else begin : g_lat3
      initial begin
        rst_n = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_addr = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // LS read of 0x40 with three-cycle latency.
        ls_req = 1'b1; ls_addr = 64'h40;
        @(negedge clk);
        chk(g, "t4 ls_gnt", 64'(ls_gnt), 64'd1);
        chk(g, "t4 ce1", 64'(mem_ce), 64'd1);
        chk(g, "t4 addr1", mem_addr, 64'h40);
        ls_req = 1'b0;
        for (int t = 0; t < 2; t++) begin
          @(negedge clk);
          chk(g, "t4 ce", 64'(mem_ce), 64'd1);
          chk(g, "t4 addr", mem_addr, 64'h40);
          chk(g, "t4 early rvalid", 64'(ls_rvalid), 64'd0);
        end
        @(negedge clk);
        chk(g, "t4 ls_rvalid", 64'(ls_rvalid), 64'd1);
        chk(g, "t4 ce off", 64'(mem_ce), 64'd0);
        chk(g, "t4 ls_rdata", 64'(ls_rdata), 64'h8DDE_6C40);
        if_req = 1'b1; if_addr = 64'h700;
        @(negedge clk);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk(g, "t4 if_rvalid", 64'(if_rvalid), 64'd1);
        chk(g, "t4 ls_rdata held", 64'(ls_rdata), 64'h8DDE_6C40);
        // Reset during the second ACCESS cycle.
        if_req = 1'b1; if_addr = 64'h500;
        @(negedge clk);
        chk(g, "t5 if_gnt", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(g, "t5 ce rst", 64'(mem_ce), 64'd0);
        chk(g, "t5 addr rst", mem_addr, 64'h0);
        chk(g, "t5 ls_rdata rst", 64'(ls_rdata), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
          @(negedge clk);
          chk(g, "t5 no rvalid", 64'(if_rvalid | ls_rvalid), 64'd0);
        end
        if_req = 1'b1; if_addr = 64'h600;
        @(negedge clk);
        chk(g, "t5 regnt", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk(g, "t5 rvalid", 64'(if_rvalid), 64'd1);
        chk(g, "t5 rdata", 64'(if_rdata), 64'(mem_f(64'h600)));
        random_phase(800);
        done = 1'b1;
      end
    end
  end

  initial begin
    for (int c = 0; c < 40000 && !(u[0].done && u[1].done); c++) @(negedge clk);
    if (!(u[0].done && u[1].done)) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: stimulus done flags %0b%0b expected 11", u[0].done, u[1].done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/quantr_mem_arbiter.md
Name: quantr_mem_arbiter

Overview:
- Sequences and shares the single instruction/data memory port between two requesters: the instruction fetch (IF) and the load/store unit (LS).
- Sits between the quantr_i core and the rom/memory block.
- Drives the memory chip-enable and address, waits a fixed memory latency, then returns read data to the owning requester.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 64, address width for requesters and memory.
- DATA_W, 32, read data width.
- MEM_LATENCY, 1, cycles from mem_ce_o assertion to valid mem_rdata_i. Legal range 1..15; out of range is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- if_req  input  1  IF read request; held with if_addr until if_gnt
- if_addr  input  ADDR_W  IF read address
- if_gnt  output  1  one-cycle grant pulse to IF
- if_rvalid  output  1  one-cycle IF read-data-valid pulse
- if_rdata  output  DATA_W  IF read data; held until next IF capture
- ls_req  input  1  LS read request
- ls_addr  input  ADDR_W  LS read address
- ls_gnt  output  1  one-cycle grant pulse to LS
- ls_rvalid  output  1  one-cycle LS read-data-valid pulse
- ls_rdata  output  DATA_W  LS read data; held until next LS capture
- mem_ce_o  output  1  memory chip enable
- mem_addr_o  output  ADDR_W  memory address
- mem_rdata_i  input  DATA_W  memory read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including rdata registers and addr; owner=IF; counter=0.
- States: IDLE and ACCESS. All outputs are registered.
- IDLE, no req: remain in IDLE; mem_ce_o=0.
- IDLE, any req at edge:
  - select winner; latch owner;
  - mem_ce_o<=1, mem_addr_o<=winner addr, winner gnt<=1 for exactly one cycle;
  - cnt<=MEM_LATENCY; go to ACCESS.
- ACCESS:
  - mem_ce_o and mem_addr_o are stable; reqs are ignored; cnt decrements each edge.
  - On the edge where cnt==1: capture mem_rdata_i into owner's rdata; owner rvalid<=1 for one cycle; mem_ce_o<=0; go to IDLE.
- Latency: req in cycle N → gnt and ce visible in N+1 → rvalid in N+1+MEM_LATENCY.
- Back-to-back: a new request may be accepted in the same cycle rvalid is high. Minimum period is MEM_LATENCY+1 cycles.
- Requester rule: after sampling gnt=1, the requester drops req or presents a new address. A req still high in the IDLE cycle after gnt is a new request.
- Default arbitration is fixed priority: LS wins over IF on simultaneous requests.
- gnt and rvalid are never asserted for both ports in the same cycle.
- Reset mid-ACCESS: transaction abandoned; no rvalid is ever issued for it.
- A req dropped before gnt (illegal): no effect beyond the IDLE sampling cycle; no latching of stale addresses.

Optional Feature:
- Macro: QUANTR_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests, the port that was NOT the last owner wins; the owner register updates on each grant. After reset, LS wins the first tie (last owner=IF).
- Undefined: fixed LS-over-IF priority as above; the owner register is used only for data steering.

Test Plan:
1. Reset release with MEM_LATENCY=1; if_req=1, if_addr=0x1000, memory returns 0x00000013 → if_gnt high in cycle 2; mem_addr_o=0x1000; if_rvalid high in cycle 3 with if_rdata=0x00000013; ls_* outputs stay 0.
2. Simultaneous if_req and ls_req (addr 0x1000 / 0x2000), fixed priority → ls granted first, ls_rdata=mem[0x2000]; IF granted at the next IDLE; two rvalids never overlap.
3. QUANTR_ARB_ROUND_ROBIN_EN defined; both requests held continuously for 4 transactions → grant order LS, IF, LS, IF.
4. MEM_LATENCY=3, single LS read of 0x40 → mem_ce_o high for 3 cycles with stable address; ls_rvalid exactly 4 cycles after ls_req sampled; ls_rdata holds until the next LS read.
5. Assert rst=0 in the second ACCESS cycle (MEM_LATENCY=3) → all outputs 0 immediately; no rvalid after release; the next if_req completes normally.
6. Continuous if_req with incrementing addresses, MEM_LATENCY=1 → one if_rvalid every 2 cycles; if_rdata matches each address in order.
